// File: rtl/wbc_vic.sv
// Vectored interrupt controller for the K1801VM2 CPU: fixed-priority request selection,
// virq generation and the vector-fetch (istb/iack/ivec) handshake.
module wbc_vic #(
   parameter int unsigned       N            = 8,
   parameter logic [N*16-1:0]   VECTORS      = '0,
   parameter logic [15:0]       SPURIOUS_VEC = 16'o000004
) (
   input  logic         wb_clk_i,
   input  logic         wb_rst_i,
   input  logic [N-1:0] ireq,
   input  logic [N-1:0] ienable,
   output logic [N-1:0] ireq_ack,
   output logic         virq,
   input  logic         istb,
   output logic [15:0]  ivec,
   output logic         iack
);

   typedef enum logic [1:0] {StIdle, StLatch, StAck, StRecover} state_e;

   state_e       state_q, state_d;
   logic         virq_q, virq_d;
   logic         iack_q, iack_d;
   logic [15:0]  ivec_q, ivec_d;
   logic [N-1:0] ack_q, ack_d;

   logic [N-1:0] pend;
   logic [N-1:0] win_onehot;
   logic [15:0]  win_vec;

   assign pend = ireq & ienable;

   // Scan from the top down so the lowest pending index is the last one written.
   always_comb begin
      win_onehot = '0;
      win_vec    = SPURIOUS_VEC;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         if (pend[k]) begin
            win_onehot    = '0;
            win_onehot[k] = 1'b1;
            win_vec       = VECTORS[16*k +: 16];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      virq_d  = virq_q;
      iack_d  = iack_q;
      ivec_d  = ivec_q;
      ack_d   = '0;
      unique case (state_q)
         StIdle: begin
            virq_d = |pend;
            if (istb) state_d = StLatch;
         end
         StLatch: begin
            // Priority is resolved here, so a late higher request still wins.
            ivec_d  = win_vec;
            ack_d   = win_onehot;
            iack_d  = 1'b1;
            virq_d  = 1'b0;
            state_d = StAck;
         end
         StAck: begin
            if (!istb) begin
               iack_d  = 1'b0;
               ivec_d  = '0;
               state_d = StRecover;
            end
         end
         StRecover: begin
            // Give the acknowledged device a cycle to drop its request.
            virq_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= StIdle;
         virq_q  <= 1'b0;
         iack_q  <= 1'b0;
         ivec_q  <= '0;
         ack_q   <= '0;
      end else begin
         state_q <= state_d;
         virq_q  <= virq_d;
         iack_q  <= iack_d;
         ivec_q  <= ivec_d;
         ack_q   <= ack_d;
      end
   end

   assign virq     = virq_q;
   assign iack     = iack_q;
   assign ivec     = ivec_q;
   assign ireq_ack = ack_q;

endmodule
